// File: rtl/sha2_pkg.sv
// sha2_pkg: shared widths and padder state encoding for the SHA-256 message padder.
`default_nettype none
package sha2_pkg;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int LEN_W       = 64;

  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_EMIT_LEN = 2'd2
  } pad_state_e;
endpackage
`default_nettype wire

// File: rtl/sha2_pad_word.sv
// sha2_pad_word: zeroes bytes past the message end in one word and places the 0x80 marker.
`default_nettype none
module sha2_pad_word
  import sha2_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [2:0]        bytes_i,
  output logic [WORD_W-1:0] word_o,
  output logic [2:0]        nbytes_o
);

  always_comb begin
    nbytes_o = (bytes_i > 3'd4) ? 3'd4 : bytes_i;
    case (nbytes_o)
      3'd0:    word_o = PAD_WORD;
      3'd1:    word_o = {data_i[31:24], 24'h80_0000};
      3'd2:    word_o = {data_i[31:16], 16'h8000};
      3'd3:    word_o = {data_i[31:8], 8'h80};
      default: word_o = data_i;  // full word: marker lands in the next word
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sha2_padder.sv
// sha2_padder: packs a big-endian 32-bit word stream into padded 512-bit SHA-256 blocks
// with the 64-bit message bit length appended to the final block.
`default_nettype none
module sha2_padder
  import sha2_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [2:0]                    in_bytes,
  output logic [BLOCK_WORDS*WORD_W-1:0] out_block,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last
);

  pad_state_e        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              needlen_q, needlen_d;
  logic              pad80_q, pad80_d;
  logic [WORD_W-1:0] buf_q [BLOCK_WORDS];
  logic [WORD_W-1:0] buf_d [BLOCK_WORDS];

  logic [WORD_W-1:0] w_word;
  logic [2:0]        w_nb;
  logic [LEN_W-1:0]  w_cnt_next;
  logic [6:0]        w_n;
  logic              w_accept;

  sha2_pad_word u_pad_word (
    .data_i   (in_data),
    .bytes_i  (in_last ? in_bytes : 3'd4),
    .word_o   (w_word),
    .nbytes_o (w_nb)
  );

  assign w_cnt_next = cnt_q + {{(LEN_W-6){1'b0}}, w_nb, 3'b000};
  assign w_n        = {1'b0, idx_q, 2'b00} + {4'b0000, w_nb};
  assign in_ready   = (state_q == ST_LOAD);
  assign out_valid  = (state_q != ST_LOAD);
  assign out_last   = last_q;
  assign w_accept   = in_valid & in_ready;

  generate
    for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_out
      assign out_block[(BLOCK_WORDS-i)*WORD_W-1 -: WORD_W] = buf_q[i];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    needlen_d = needlen_q;
    pad80_d   = pad80_q;
    buf_d     = buf_q;
    case (state_q)
      ST_LOAD: begin
        if (w_accept) begin
          buf_d[idx_q] = w_word;
          cnt_d        = w_cnt_next;
          idx_d        = idx_q + 4'd1;
          if (in_last) begin
            for (int j = 0; j < BLOCK_WORDS; j++) begin
              if (4'(j) > idx_q) buf_d[4'(j)] = '0;
            end
            if (w_nb == 3'd4 && idx_q != 4'd15) buf_d[idx_q + 4'd1] = PAD_WORD;
            // Length fits after the marker only when the message leaves 8 free bytes.
            if (w_n <= 7'd55) begin
              buf_d[14] = w_cnt_next[63:32];
              buf_d[15] = w_cnt_next[31:0];
              last_d    = 1'b1;
              needlen_d = 1'b0;
            end else begin
              last_d    = 1'b0;
              needlen_d = 1'b1;
            end
            pad80_d = (w_n == 7'd64);
            state_d = ST_EMIT;
          end else if (idx_q == 4'd15) begin
            last_d    = 1'b0;
            needlen_d = 1'b0;
            state_d   = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (needlen_q) begin
            for (int j = 0; j < BLOCK_WORDS; j++) buf_d[4'(j)] = '0;
            buf_d[0]  = pad80_q ? PAD_WORD : '0;
            buf_d[14] = cnt_q[63:32];
            buf_d[15] = cnt_q[31:0];
            last_d    = 1'b1;
            needlen_d = 1'b0;
            pad80_d   = 1'b0;
            state_d   = ST_EMIT_LEN;
          end else begin
            if (last_q) cnt_d = '0;
            last_d  = 1'b0;
            idx_d   = 4'd0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_EMIT_LEN: begin
        if (out_ready) begin
          cnt_d   = '0;
          idx_d   = 4'd0;
          last_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      idx_q     <= 4'd0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      needlen_q <= 1'b0;
      pad80_q   <= 1'b0;
      for (int j = 0; j < BLOCK_WORDS; j++) buf_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      needlen_q <= needlen_d;
      pad80_q   <= pad80_d;
      buf_q     <= buf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha2_padder.sv
// tb_sha2_padder: directed vectors for the SHA-256 padder with hand-computed blocks.
`default_nettype none
module tb_sha2_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [511:0] exp_blk;
  logic [511:0] got_blk;
  logic         got_last;

  sha2_padder dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] msg_word(input int i);
    return {8'(i), 8'hA5, 8'(i + 16), 8'h5A};
  endfunction

  task automatic put(input int i, input logic [31:0] v);
    exp_blk[511 - 32*i -: 32] = v;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t = 0;
    @(negedge clk);
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 512'd0, 512'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(output logic [511:0] b, output logic l);
    int t = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("out_valid_timeout", 512'd0, 512'd1);
    b = out_block;
    l = out_last;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_block", out_block, 512'd0);
    chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("rst_out_last", {511'd0, out_last}, 512'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {511'd0, in_ready}, 512'd1);

    // "abc"
    send_word(32'h6162_6300, 1'b1, 3'd3);
    chk("abc_latency", {511'd0, out_valid}, 512'd1);
    recv(got_blk, got_last);
    exp_blk = '0; put(0, 32'h6162_6380); put(15, 32'h0000_0018);
    chk("abc_block", got_blk, exp_blk);
    chk("abc_last", {511'd0, got_last}, 512'd1);

    // empty message
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    recv(got_blk, got_last);
    exp_blk = '0; put(0, 32'h8000_0000);
    chk("empty_block", got_blk, exp_blk);
    chk("empty_last", {511'd0, got_last}, 512'd1);

    // in_bytes=7 clamps to a full word; first word's in_bytes ignored when not last
    send_word(32'h4142_4344, 1'b1, 3'd7);
    recv(got_blk, got_last);
    exp_blk = '0; put(0, 32'h4142_4344); put(1, 32'h8000_0000); put(15, 32'h0000_0020);
    chk("bytes7_block", got_blk, exp_blk);
    send_word(32'h6162_6364, 1'b0, 3'd1);
    send_word(32'h6465_FFFF, 1'b1, 3'd2);
    recv(got_blk, got_last);
    exp_blk = '0; put(0, 32'h6162_6364); put(1, 32'h6465_8000); put(15, 32'h0000_0030);
    chk("two_word_block", got_blk, exp_blk);

    // 56-byte message
    for (int i = 0; i < 14; i++) send_word(msg_word(i), (i == 13), 3'd4);
    recv(got_blk, got_last);
    chk("m56_emitlen_latency", {511'd0, out_valid}, 512'd1);
    exp_blk = '0;
    for (int i = 0; i < 14; i++) put(i, msg_word(i));
    put(14, 32'h8000_0000);
    chk("m56_blk1", got_blk, exp_blk);
    chk("m56_last1", {511'd0, got_last}, 512'd0);
    recv(got_blk, got_last);
    exp_blk = '0; put(15, 32'h0000_01C0);
    chk("m56_blk2", got_blk, exp_blk);
    chk("m56_last2", {511'd0, got_last}, 512'd1);

    // 60-byte message: marker fits, length spills
    for (int i = 0; i < 15; i++) send_word(msg_word(i + 40), (i == 14), 3'd4);
    recv(got_blk, got_last);
    exp_blk = '0;
    for (int i = 0; i < 15; i++) put(i, msg_word(i + 40));
    put(15, 32'h8000_0000);
    chk("m60_blk1", got_blk, exp_blk);
    recv(got_blk, got_last);
    exp_blk = '0; put(15, 32'h0000_01E0);
    chk("m60_blk2", got_blk, exp_blk);

    // 64-byte message
    for (int i = 0; i < 16; i++) send_word(msg_word(i + 20), (i == 15), 3'd4);
    recv(got_blk, got_last);
    exp_blk = '0;
    for (int i = 0; i < 16; i++) put(i, msg_word(i + 20));
    chk("m64_blk1", got_blk, exp_blk);
    chk("m64_last1", {511'd0, got_last}, 512'd0);
    recv(got_blk, got_last);
    exp_blk = '0; put(0, 32'h8000_0000); put(15, 32'h0000_0200);
    chk("m64_blk2", got_blk, exp_blk);
    chk("m64_last2", {511'd0, got_last}, 512'd1);

    // backpressure: garbage past in_bytes must be masked, block held while stalled
    send_word(32'h6162_63FF, 1'b1, 3'd3);
    exp_blk = '0; put(0, 32'h6162_6380); put(15, 32'h0000_0018);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_block", out_block, exp_blk);
      chk("stall_in_ready", {511'd0, in_ready}, 512'd0);
      chk("stall_valid", {510'd0, out_valid, out_last}, 512'd3);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("stall_release", {511'd0, out_valid}, 512'd0);

    // reset mid-message
    for (int i = 0; i < 7; i++) send_word(msg_word(i), 1'b0, 3'd4);
    @(negedge clk);
    rst = 1'b1; #2; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {511'd0, out_valid}, 512'd0);
    chk("rst_mid_ready", {511'd0, in_ready}, 512'd1);

    // reset mid-EMIT
    for (int i = 0; i < 16; i++) send_word(msg_word(i), 1'b0, 3'd4);
    chk("full_blk_valid", {511'd0, out_valid}, 512'd1);
    @(negedge clk);
    rst = 1'b1; #2; rst = 1'b0;
    @(negedge clk);
    chk("rst_emit_valid", {511'd0, out_valid}, 512'd0);

    send_word(32'h6162_6300, 1'b1, 3'd3);
    recv(got_blk, got_last);
    exp_blk = '0; put(0, 32'h6162_6380); put(15, 32'h0000_0018);
    chk("post_rst_abc", got_blk, exp_blk);
    chk("post_rst_last", {511'd0, got_last}, 512'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
